// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single data memory.
// Each grant becomes a one-cycle memory access followed by a one-cycle ack pulse.
module dm_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [31:0]       pc0,
    input  logic [31:0]       pc1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       mem_pc,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_start;
    logic              w_gnt;
    logic              r_prio;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // A lone requester wins outright; prio only breaks ties.
    assign w_gnt = (req0 && req1) ? r_prio : req1;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        mem_we  = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        busy    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_next  = ACCESS;
                    w_start = 1'b1;
                end
            end
            ACCESS: begin
                w_next = RESP;
                mem_we = r_we;
                busy   = 1'b1;
            end
            RESP: begin
                w_next = IDLE;
                busy   = 1'b1;
                ack0   = ~r_owner;
                ack1   = r_owner;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_start) begin
                r_owner <= w_gnt;
                r_prio  <= ~w_gnt;
                r_we    <= w_gnt ? we1    : we0;
                r_addr  <= w_gnt ? addr1  : addr0;
                r_wdata <= w_gnt ? wdata1 : wdata0;
                r_pc    <= w_gnt ? pc1    : pc0;
            end
            // For a write this deliberately captures the pre-write word.
            if (r_state == ACCESS) begin
                if (r_owner) begin
                    r_rdata1 <= mem_rdata;
                end else begin
                    r_rdata0 <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_pc    = r_pc;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word memory model attached to mem_*.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
    logic        ack0, ack1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_pc, mem_rdata;

    logic        tb_init;
    logic [31:0] mem [0:63];

    int n_tests;
    int n_fail;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .pc0(pc0), .pc1(pc1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_pc(mem_pc), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'hA0A0A0A0;
            mem[1]  <= 32'hB1B1B1B1;
            mem[4]  <= 32'hDEADBEEF;
            mem[16] <= 32'h11111111;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; tb_init = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0; pc1 = 0;
        step(); step();
        tb_init = 1'b0;
        reset = 1'b0;
        #1;

        // Reset values
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_pc", mem_pc, 0);
        chk("rst_busy", busy, 0);

        // Read, port 0
        req0 = 1; we0 = 0; addr0 = 32'h10; pc0 = 32'h1000;
        step();
        chk("rd0_acc_busy", busy, 1);
        chk("rd0_acc_we", mem_we, 0);
        chk("rd0_acc_addr", mem_addr, 32'h10);
        chk("rd0_acc_ack0", ack0, 0);
        step();
        chk("rd0_resp_ack0", ack0, 1);
        chk("rd0_resp_ack1", ack1, 0);
        chk("rd0_resp_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd0_resp_we", mem_we, 0);
        req0 = 0;
        step();
        chk("rd0_idle_ack0", ack0, 0);
        chk("rd0_idle_busy", busy, 0);

        // Write then read, port 1
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678; pc1 = 32'h3000;
        step();
        chk("wr1_acc_we", mem_we, 1);
        chk("wr1_acc_pc", mem_pc, 32'h3000);
        chk("wr1_acc_addr", mem_addr, 32'h20);
        chk("wr1_acc_wdata", mem_wdata, 32'h12345678);
        step();
        chk("wr1_resp_we", mem_we, 0);
        chk("wr1_resp_ack1", ack1, 1);
        chk("wr1_resp_ack0", ack0, 0);
        chk("wr1_resp_rdata1", rdata1, 32'h0);
        chk("wr1_mem", mem[8], 32'h12345678);
        chk("rdata0_hold", rdata0, 32'hDEADBEEF);
        req1 = 0;
        step();
        chk("wr1_idle_we", mem_we, 0);
        chk("wr1_idle_pc_hold", mem_pc, 32'h3000);
        req1 = 1; we1 = 0;
        step();
        chk("rd1_acc_we", mem_we, 0);
        step();
        chk("rd1_resp_ack1", ack1, 1);
        chk("rd1_resp_rdata1", rdata1, 32'h12345678);
        req1 = 0;
        step();

        // Contention after reset: grants alternate 0,1,0,1 three cycles apart
        reset = 1; #1; reset = 0;
        req0 = 1; we0 = 0; addr0 = 32'h0;
        req1 = 1; we1 = 0; addr1 = 32'h4;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("cont_busy", busy, (k % 3) != 0);
            chk("cont_ack0", ack0, (k % 3 == 2) && (((k - 1) / 3) % 2 == 0));
            chk("cont_ack1", ack1, (k % 3 == 2) && (((k - 1) / 3) % 2 == 1));
            if (k == 2) chk("cont_rdata0", rdata0, 32'hA0A0A0A0);
            if (k == 5) chk("cont_rdata1", rdata1, 32'hB1B1B1B1);
        end
        req0 = 0; req1 = 0;
        step();
        chk("cont_end_busy", busy, 0);
        step();
        chk("cont_stay_idle", busy, 0);

        // Single contender: req1 rises while port 0 is in ACCESS
        req0 = 1; addr0 = 32'h10;
        step();
        chk("sc_acc0_addr", mem_addr, 32'h10);
        req1 = 1; addr1 = 32'h4;
        step();
        chk("sc_ack0_first", ack0, 1);
        step();
        step();
        chk("sc_acc1_addr", mem_addr, 32'h4);
        step();
        chk("sc_ack1", ack1, 1);
        chk("sc_ack1_ack0", ack0, 0);
        req1 = 0;
        step();
        step();
        chk("sc_next0_addr", mem_addr, 32'h10);
        step();
        chk("sc_next0_ack0", ack0, 1);
        req0 = 0;
        step();

        // Payload change after grant
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h55AA55AA; pc0 = 32'h100;
        step();
        addr0 = 32'h34; wdata0 = 32'h0; pc0 = 32'h200;
        #1;
        chk("pl_we", mem_we, 1);
        chk("pl_addr", mem_addr, 32'h30);
        chk("pl_wdata", mem_wdata, 32'h55AA55AA);
        chk("pl_pc", mem_pc, 32'h100);
        step();
        chk("pl_ack0", ack0, 1);
        chk("pl_rdata0_old", rdata0, 32'h0);
        req0 = 0;
        step();
        chk("pl_mem30", mem[12], 32'h55AA55AA);
        chk("pl_mem34", mem[13], 32'h0);
        chk("pl_addr_hold", mem_addr, 32'h30);

        // Reset asserted during a write's ACCESS cycle
        req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hFFFFFFFF;
        step();
        chk("rw_acc_we", mem_we, 1);
        #2;
        reset = 1;
        #1;
        chk("rw_we_drop", mem_we, 0);
        chk("rw_busy", busy, 0);
        chk("rw_addr", mem_addr, 0);
        chk("rw_rdata1", rdata1, 0);
        step();
        chk("rw_mem40", mem[16], 32'h11111111);
        chk("rw_ack0", ack0, 0);
        req0 = 0;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rw_no_ack0", ack0, 0);
            chk("rw_no_busy", busy, 0);
        end
        chk("rw_mem40_end", mem[16], 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single data memory between two requesters: port 0 (CPU load/store stage) and port 1 (auxiliary master, e.g. a debug/loader engine). It accepts word-wide read/write requests over a req/ack handshake. Round-robin arbitration picks one requester at a time, and the chosen transaction goes to the memory as a one-cycle access. Read data comes back registered with a one-cycle ack pulse. It sits directly in front of the data memory, and its `mem_*` outputs connect to the memory's write-enable, address, write-data and trace-PC inputs.

## Interface
Parameters:
- `ADDR_W`, 32, address width of requests and memory address.
- `DATA_W`, 32, data word width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req0`, `req1`  in  1  transaction request, port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  byte address; passed unmodified to the memory, which uses word bits.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `pc0`, `pc1`  in  32  PC of the issuing instruction; forwarded for the memory write trace.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_W  read data; valid when ack is high, held until that port's next ack.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_pc`  out  32  trace PC to memory.
- `mem_rdata`  in  DATA_W  combinational memory read data.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS if `req0 | req1`; otherwise stays in IDLE.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Requests are sampled only in IDLE.
- On the IDLE→ACCESS edge the winner's `we`, `addr`, `wdata` and `pc` are latched, along with `owner`. Later changes on the request inputs do not affect the transaction in flight.
- Arbitration:
  - If only one port requests, that port wins.
  - If both request, the port selected by the priority bit `prio` wins (0 = port 0, 1 = port 1).
  - After every grant, `prio` becomes the non-granted port.
- ACCESS:
  - `mem_addr`, `mem_wdata` and `mem_pc` come from the latches.
  - `mem_we` equals the latched `we`, so the memory writes on the edge ending ACCESS.
  - On that same edge, `mem_rdata` is captured into `rdata[owner]`. For a write this captures the pre-write word.
- RESP: `ack[owner]` = 1 and the other ack = 0.
- In IDLE and RESP, `mem_we` = 0 and `mem_addr`/`mem_wdata`/`mem_pc` hold their last latched values.
- Requester rule:
  - Hold `req` and its payload until ack is seen.
  - `req` still high in the IDLE cycle after RESP counts as a new transaction.

## Timing
- Reset values:
  - State: IDLE, `prio` = 0, `owner` = 0.
  - Outputs: `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `mem_we` = 0, `mem_addr` = `mem_wdata` = `mem_pc` = 0, `busy` = 0.
- Latency: `req` high in IDLE at edge N → ACCESS in cycle N+1 → `ack` high in cycle N+2. Ack follows request acceptance by exactly 2 cycles.
- Throughput: at most one transaction per 3 cycles.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1… No port waits more than one other transaction (≤ 5 cycles from request to ack).
- Reset asserted mid-operation:
  - All registers clear asynchronously and `mem_we` drops at once, so a write in ACCESS is not performed.
  - A pending ack is lost; the requester re-issues after reset.
- `req0` and `req1` rising in the same cycle: tie broken by `prio`. No ack ever goes to a port that did not request.

## Test plan
- Read, port 0:
  - Stimulus: memory word 0x10 = 0xDEADBEEF; `req0`=1, `we0`=0, `addr0`=0x10 in IDLE.
  - Response: `mem_we`=0 throughout; `ack0` pulses 2 cycles later with `rdata0`=0xDEADBEEF; `ack1` stays 0.
- Write then read, port 1:
  - Stimulus: write 0x12345678 to 0x20 with `pc1`=0x3000; then read 0x20.
  - Response: `mem_we`=1 for exactly one cycle with `mem_pc`=0x3000; the write's `rdata1` = old value 0; the read returns 0x12345678.
- Contention:
  - Stimulus: both ports hold `req` continuously after reset, with port 0 reading 0x0 and port 1 reading 0x4.
  - Response: acks arrive in order `ack0`, `ack1`, `ack0`, `ack1`, 3 cycles apart; `busy` is low in exactly one cycle between transactions.
- Single contender:
  - Stimulus: `req0` continuous; `req1` pulsed once while port 0 is in ACCESS.
  - Response: `ack1` arrives after at most one further port-0 transaction; port 0 is then granted next.
- Reset mid-write:
  - Stimulus: port 0 writes 0xFFFFFFFF to 0x40; assert `reset` during ACCESS before the clock edge.
  - Response: `mem_we` drops immediately; word 0x40 is unchanged; `ack0` never pulses; all outputs hold reset values.
- Payload change after grant:
  - Stimulus: change `addr0`/`wdata0` during ACCESS.
  - Response: memory sees only the latched values.
